// File: rtl/irig_pkg.sv
// irig_pkg
// Shared definitions for the IRIG frame blocks: frame-sync FSM states,
// frame geometry (marker positions, last position), the layout of the
// decoded time fields and the default watchdog timeout.
// Helpers:
//   is_marker_pos(pos) - 1 when a marker symbol is expected at pos
//   field_bit(pos)     - where a data bit at pos lands in the field stage
package irig_pkg;

   // Clocks without a symbol before alignment is abandoned (1.5 bits @ 10 MHz)
   localparam int unsigned TIMEOUT_DEFAULT = 150000;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ARM    = 2'd1,
      TRACK  = 2'd2
   } state_e;

   localparam logic [6:0] POS_PR   = 7'd0;
   localparam logic [6:0] POS_LAST = 7'd99;

   // Decoded field widths and their LSB offsets inside the field stage
   localparam int unsigned SEC_W    = 7;
   localparam int unsigned MIN_W    = 7;
   localparam int unsigned HOUR_W   = 6;
   localparam int unsigned DAY_W    = 10;
   localparam int unsigned YEAR_W   = 8;
   localparam int unsigned SEC_LSB  = 0;
   localparam int unsigned MIN_LSB  = 7;
   localparam int unsigned HOUR_LSB = 14;
   localparam int unsigned DAY_LSB  = 20;
   localparam int unsigned YEAR_LSB = 30;
   localparam int unsigned STAGE_W  = 38;

   // BCD digit segments: frame start/end position and the stage bit that
   // receives the digit LSB (the first bit transmitted).
   localparam logic [3:0] NUM_SEG = 4'd11;
   localparam logic [6:0] SEG_START [NUM_SEG] = '{7'd1,  7'd6,  7'd10, 7'd15, 7'd20, 7'd25,
                                                   7'd30, 7'd35, 7'd40, 7'd50, 7'd55};
   localparam logic [6:0] SEG_END   [NUM_SEG] = '{7'd4,  7'd8,  7'd13, 7'd17, 7'd23, 7'd26,
                                                   7'd33, 7'd38, 7'd41, 7'd53, 7'd58};
   localparam logic [5:0] SEG_BASE  [NUM_SEG] = '{6'd0,  6'd4,  6'd7,  6'd11, 6'd14, 6'd18,
                                                   6'd20, 6'd24, 6'd28, 6'd30, 6'd34};

   typedef struct packed {
      logic       hit;
      logic [5:0] idx;
   } fbit_t;

   // Pr (position 0) and every position ending in 9 carry a marker
   function automatic logic is_marker_pos(input logic [6:0] pos);
      return (pos == POS_PR) || ((pos % 7'd10) == 7'd9);
   endfunction

   // Map a frame position to its stage bit; hit=0 for discarded positions
   function automatic fbit_t field_bit(input logic [6:0] pos);
      fbit_t r;
      r = '0;
      for (logic [3:0] f = 4'd0; f < NUM_SEG; f++) begin
         if ((pos >= SEG_START[f]) && (pos <= SEG_END[f])) begin
            r.hit = 1'b1;
            r.idx = SEG_BASE[f] + 6'(pos - SEG_START[f]);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/irig_watchdog.sv
// irig_watchdog
// Saturating inactivity counter for IRIG symbol streams.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   clear_i   in  a symbol arrived this cycle; restart the count
//   enable_i  in  counting allowed; held at zero otherwise
//   timeout_o out high in the cycle whose edge brings the count to
//                 TIMEOUT_CYCLES, so a registered consumer reacts in the
//                 first cycle the count reads TIMEOUT_CYCLES
module irig_watchdog
   import irig_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic timeout_o
);

   localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear on symbol or when idle, saturate at the limit
   always_comb begin
      cnt_d = cnt_q;
      if (!enable_i || clear_i) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_o = enable_i && !clear_i && (cnt_q == CNT_PRE);

endmodule

// File: rtl/irig_frame_sync.sv
// irig_frame_sync
// Aligns to the IRIG-B 100-symbol frame, pulses pps on each reference
// marker and publishes the BCD time fields once per complete frame.
// Ports:
//   clk, rst             10 MHz clock, synchronous active-high reset
//   irig_mark/d0/d1      one-cycle decoded symbol pulses
//   locked               frame alignment held
//   pps                  pulse on each accepted Pr marker
//   ts_valid             pulse when ts_* carry a freshly completed frame
//   ts_sec/min/hour/day/year  BCD time fields, held between frames
//   frame_err            pulse on loss of alignment
module irig_frame_sync
   import irig_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        irig_mark,
   input  logic        irig_d0,
   input  logic        irig_d1,
   output logic        locked,
   output logic        pps,
   output logic        ts_valid,
   output logic [6:0]  ts_sec,
   output logic [6:0]  ts_min,
   output logic [5:0]  ts_hour,
   output logic [9:0]  ts_day,
   output logic [7:0]  ts_year,
   output logic        frame_err
);

   state_e               state_q, state_d;
   logic [6:0]           pos_q, pos_d;          // position of the next expected symbol
   logic [STAGE_W-1:0]   stage_q, stage_d;
   logic                 locked_q, locked_d;
   logic                 pps_q, pps_d;
   logic                 ts_valid_q, ts_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic [SEC_W-1:0]     ts_sec_q, ts_sec_d;
   logic [MIN_W-1:0]     ts_min_q, ts_min_d;
   logic [HOUR_W-1:0]    ts_hour_q, ts_hour_d;
   logic [DAY_W-1:0]     ts_day_q, ts_day_d;
   logic [YEAR_W-1:0]    ts_year_q, ts_year_d;

   logic [1:0]           hot_cnt_s;
   logic                 sym_s;
   logic                 multi_s;
   logic                 wd_timeout_s;
   fbit_t                fb_s;

   assign hot_cnt_s = {1'b0, irig_mark} + {1'b0, irig_d0} + {1'b0, irig_d1};
   assign sym_s     = (hot_cnt_s == 2'd1);
   assign multi_s   = (hot_cnt_s >= 2'd2);
   assign fb_s      = field_bit(pos_q);

   irig_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (sym_s),
      .enable_i  (state_q != SEARCH),
      .timeout_o (wd_timeout_s)
   );

   // Frame-sync next state, field capture and output pulses
   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      stage_d     = stage_q;
      locked_d    = locked_q;
      pps_d       = 1'b0;
      ts_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      ts_sec_d    = ts_sec_q;
      ts_min_d    = ts_min_q;
      ts_hour_d   = ts_hour_q;
      ts_day_d    = ts_day_q;
      ts_year_d   = ts_year_q;
      case (state_q)
         SEARCH: begin
            if (sym_s && irig_mark) begin
               state_d = ARM;
            end else begin
               state_d = SEARCH;
            end
         end
         ARM: begin
            // Two consecutive markers (P0, Pr) establish alignment
            if (wd_timeout_s) begin
               state_d = SEARCH;
            end else if (sym_s && irig_mark) begin
               state_d  = TRACK;
               pos_d    = 7'd1;
               pps_d    = 1'b1;
               locked_d = 1'b1;
            end else if (sym_s) begin
               state_d = SEARCH;
            end else begin
               state_d = ARM;
            end
         end
         TRACK: begin
            if (multi_s || wd_timeout_s ||
                (sym_s && (irig_mark != is_marker_pos(pos_q)))) begin
               state_d     = SEARCH;
               pos_d       = 7'd0;
               locked_d    = 1'b0;
               frame_err_d = 1'b1;
            end else if (sym_s) begin
               pos_d = (pos_q == POS_LAST) ? POS_PR : (pos_q + 7'd1);
               if (irig_mark) begin
                  if (pos_q == POS_LAST) begin
                     ts_sec_d   = stage_q[SEC_LSB  +: SEC_W];
                     ts_min_d   = stage_q[MIN_LSB  +: MIN_W];
                     ts_hour_d  = stage_q[HOUR_LSB +: HOUR_W];
                     ts_day_d   = stage_q[DAY_LSB  +: DAY_W];
                     ts_year_d  = stage_q[YEAR_LSB +: YEAR_W];
                     ts_valid_d = 1'b1;
                  end else begin
                     pps_d = (pos_q == POS_PR);
                  end
               end else if (fb_s.hit) begin
                  stage_d[fb_s.idx] = irig_d1;
               end else begin
                  stage_d = stage_q;
               end
            end else begin
               state_d = TRACK;
            end
         end
         default: begin
            state_d  = SEARCH;
            pos_d    = 7'd0;
            locked_d = 1'b0;
         end
      endcase
   end

   // State, stage and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SEARCH;
         pos_q       <= 7'd0;
         stage_q     <= '0;
         locked_q    <= 1'b0;
         pps_q       <= 1'b0;
         ts_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         ts_sec_q    <= '0;
         ts_min_q    <= '0;
         ts_hour_q   <= '0;
         ts_day_q    <= '0;
         ts_year_q   <= '0;
      end else begin
         state_q     <= state_d;
         pos_q       <= pos_d;
         stage_q     <= stage_d;
         locked_q    <= locked_d;
         pps_q       <= pps_d;
         ts_valid_q  <= ts_valid_d;
         frame_err_q <= frame_err_d;
         ts_sec_q    <= ts_sec_d;
         ts_min_q    <= ts_min_d;
         ts_hour_q   <= ts_hour_d;
         ts_day_q    <= ts_day_d;
         ts_year_q   <= ts_year_d;
      end
   end

   assign locked    = locked_q;
   assign pps       = pps_q;
   assign ts_valid  = ts_valid_q;
   assign frame_err = frame_err_q;
   assign ts_sec    = ts_sec_q;
   assign ts_min    = ts_min_q;
   assign ts_hour   = ts_hour_q;
   assign ts_day    = ts_day_q;
   assign ts_year   = ts_year_q;

endmodule

// File: tb/tb_irig_frame_sync.sv
// tb_irig_frame_sync
// Directed bench for irig_frame_sync. Stimulus pushes the expected output
// event (pps / ts_valid / frame_err with cycle and field values) into a
// queue; an independent monitor pops and compares whenever the DUT pulses.
// A shortened watchdog timeout keeps the run short.
module tb_irig_frame_sync;

   localparam int unsigned TO = 1000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       irig_mark = 1'b0;
   logic       irig_d0 = 1'b0;
   logic       irig_d1 = 1'b0;
   logic       locked, pps, ts_valid, frame_err;
   logic [6:0] ts_sec, ts_min;
   logic [5:0] ts_hour;
   logic [9:0] ts_day;
   logic [7:0] ts_year;

   irig_frame_sync #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .irig_mark (irig_mark),
      .irig_d0   (irig_d0),
      .irig_d1   (irig_d1),
      .locked    (locked),
      .pps       (pps),
      .ts_valid  (ts_valid),
      .ts_sec    (ts_sec),
      .ts_min    (ts_min),
      .ts_hour   (ts_hour),
      .ts_day    (ts_day),
      .ts_year   (ts_year),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;
   int n_tsv = 0;
   int last_edge = 0;

   typedef struct packed {
      logic [31:0] cyc;
      logic        pps;
      logic        tsv;
      logic        err;
      logic        lck;
      logic [6:0]  sec;
      logic [6:0]  mi;
      logic [5:0]  hour;
      logic [9:0]  day;
      logic [7:0]  year;
   } exp_t;

   exp_t q[$];
   exp_t me;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t ev(input logic p, input logic t, input logic r, input logic l);
      exp_t e;
      e = '0;
      e.pps = p; e.tsv = t; e.err = r; e.lck = l;
      return e;
   endfunction

   // Monitor: every output pulse must match the oldest expected event
   always @(negedge clk) begin
      if (pps === 1'b1 || ts_valid === 1'b1 || frame_err === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_event", {61'd0, pps, ts_valid, frame_err}, 64'd0);
         end else begin
            me = q.pop_front();
            chk("event_cycle", cyc, me.cyc);
            chk("event_pps", pps, me.pps);
            chk("event_ts_valid", ts_valid, me.tsv);
            chk("event_frame_err", frame_err, me.err);
            chk("event_locked", locked, me.lck);
            if (me.tsv) begin
               n_tsv++;
               chk("ts_sec", ts_sec, me.sec);
               chk("ts_min", ts_min, me.mi);
               chk("ts_hour", ts_hour, me.hour);
               chk("ts_day", ts_day, me.day);
               chk("ts_year", ts_year, me.year);
            end
         end
      end else if (q.size() != 0 && cyc > int'(q[0].cyc)) begin
         me = q.pop_front();
         chk("missed_event_cycle", cyc, me.cyc);
      end
   end

   // One symbol: high for one cycle, sampled at the following posedge
   task automatic drive(input logic m, input logic z, input logic o,
                        input logic has_exp, input exp_t e);
      exp_t t;
      @(negedge clk);
      irig_mark = m; irig_d0 = z; irig_d1 = o;
      last_edge = cyc + 1;
      if (has_exp) begin
         t = e;
         t.cyc = 32'(cyc + 1);
         q.push_back(t);
      end
      @(negedge clk);
      irig_mark = 1'b0; irig_d0 = 1'b0; irig_d1 = 1'b0;
   endtask

   // Frame positions 1..upto; unused data positions carry 1s
   task automatic send_body(input logic [6:0] s, input logic [6:0] mi, input logic [5:0] h,
                            input logic [9:0] d, input logic [7:0] y, input int upto);
      logic [99:0] f;
      exp_t e;
      f = '1;
      for (int i = 0; i < 4; i++) begin
         f[1+i] = s[i]; f[10+i] = mi[i]; f[20+i] = h[i]; f[30+i] = d[i]; f[50+i] = y[i];
         f[35+i] = d[4+i]; f[55+i] = y[4+i];
      end
      for (int i = 0; i < 3; i++) begin
         f[6+i] = s[4+i]; f[15+i] = mi[4+i];
      end
      f[25] = h[4]; f[26] = h[5]; f[40] = d[8]; f[41] = d[9];
      for (int p = 1; p <= upto; p++) begin
         if (p == 99) begin
            e = ev(1'b0, 1'b1, 1'b0, 1'b1);
            e.sec = s; e.mi = mi; e.hour = h; e.day = d; e.year = y;
            drive(1'b1, 1'b0, 1'b0, 1'b1, e);
         end else if (p % 10 == 9) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0));
         end else begin
            drive(1'b0, ~f[p], f[p], 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0));
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_locked"}, locked, 64'd0);
      chk({tag, "_pps"}, pps, 64'd0);
      chk({tag, "_ts_valid"}, ts_valid, 64'd0);
      chk({tag, "_frame_err"}, frame_err, 64'd0);
      chk({tag, "_ts"}, {ts_sec, ts_min, ts_hour, ts_day, ts_year}, 64'd0);
   endtask

   initial begin
      exp_t e0;
      exp_t e;
      e0 = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Simultaneous mark+d0 in SEARCH is no symbol: one real mark only arms
      drive(1'b1, 1'b1, 1'b0, 1'b0, e0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, e0);
      chk("search_multi_ignored", locked, 64'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, ev(1'b1, 1'b0, 1'b0, 1'b1));
      chk("lock_after_pr", locked, 64'd1);

      // Three consecutive legal frames
      send_body(7'h58, 7'h59, 6'h23, 10'h365, 8'h24, 99);
      drive(1'b1, 1'b0, 1'b0, 1'b1, ev(1'b1, 1'b0, 1'b0, 1'b1));
      send_body(7'h07, 7'h34, 6'h12, 10'h123, 8'h25, 99);
      drive(1'b1, 1'b0, 1'b0, 1'b1, ev(1'b1, 1'b0, 1'b0, 1'b1));
      send_body(7'h41, 7'h02, 6'h01, 10'h045, 8'h99, 99);
      drive(1'b1, 1'b0, 1'b0, 1'b1, ev(1'b1, 1'b0, 1'b0, 1'b1));

      // d1 where the pos-19 marker belongs
      send_body(7'h58, 7'h59, 6'h23, 10'h365, 8'h24, 18);
      drive(1'b0, 1'b0, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b1, 1'b0));
      chk("wrong_type_unlocked", locked, 64'd0);
      chk("wrong_type_ts_held", {ts_sec, ts_min, ts_hour, ts_day, ts_year},
          {7'h41, 7'h02, 6'h01, 10'h045, 8'h99});

      // Silence while locked
      drive(1'b1, 1'b0, 1'b0, 1'b0, e0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, ev(1'b1, 1'b0, 1'b0, 1'b1));
      e = ev(1'b0, 1'b0, 1'b1, 1'b0);
      e.cyc = 32'(last_edge + int'(TO));
      q.push_back(e);
      repeat (TO + 5) @(negedge clk);
      chk("timeout_unlocked", locked, 64'd0);

      // mark+d0 together while locked
      drive(1'b1, 1'b0, 1'b0, 1'b0, e0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, ev(1'b1, 1'b0, 1'b0, 1'b1));
      send_body(7'h58, 7'h59, 6'h23, 10'h365, 8'h24, 3);
      drive(1'b1, 1'b1, 1'b0, 1'b1, ev(1'b0, 1'b0, 1'b1, 1'b0));
      chk("multi_unlocked", locked, 64'd0);

      // ARM times out silently; next mark only re-arms
      drive(1'b1, 1'b0, 1'b0, 1'b0, e0);
      repeat (TO + 10) @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, e0);
      chk("arm_timeout_no_lock", locked, 64'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, ev(1'b1, 1'b0, 1'b0, 1'b1));

      // Reset at pos 45, then relock on a full frame
      send_body(7'h07, 7'h34, 6'h12, 10'h123, 8'h25, 44);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midframe_reset");
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, e0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, ev(1'b1, 1'b0, 1'b0, 1'b1));
      send_body(7'h33, 7'h16, 6'h09, 10'h287, 8'h31, 99);

      repeat (10) @(negedge clk);
      chk("events_drained", q.size(), 64'd0);
      chk("ts_valid_count", n_tsv, 64'd4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/irig_frame_sync.md
IRIG_FRAME_SYNC -- requirements
Module: irig_frame_sync

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 150000, clocks with no symbol pulse before lock is dropped (1.5 bit periods at 10 MHz).
REQ-002 Port: clk  in  1  system clock (10 MHz); the only clock.
REQ-003 Port: rst  in  1  reset; synchronous and active-high.
REQ-004 Port: irig_mark  in  1  one-cycle pulse, decoded marker symbol.
REQ-005 Port: irig_d0  in  1  one-cycle pulse, decoded data bit value 0.
REQ-006 Port: irig_d1  in  1  one-cycle pulse, decoded data bit value 1.
REQ-007 Port: locked  out  1  high while frame alignment is held.
REQ-008 Port: pps  out  1  one-cycle pulse on each accepted reference marker (Pr).
REQ-009 Port: ts_valid  out  1  one-cycle pulse when a complete frame's fields are valid.
REQ-010 Port: ts_sec  out  7  BCD seconds, {tens[2:0], units[3:0]}.
REQ-011 Port: ts_min  out  7  BCD minutes, {tens[2:0], units[3:0]}.
REQ-012 Port: ts_hour  out  6  BCD hours, {tens[1:0], units[3:0]}.
REQ-013 Port: ts_day  out  10  BCD day-of-year, {hundreds[1:0], tens[3:0], units[3:0]}.
REQ-014 Port: ts_year  out  8  BCD year, {tens[3:0], units[3:0]}.
REQ-015 Port: frame_err  out  1  one-cycle pulse on any loss of alignment.

Function
REQ-016 A "symbol" is a cycle with exactly one of irig_mark, irig_d0 or irig_d1 high.
REQ-017 The FSM states are SEARCH, ARM and TRACK.
- SEARCH: a mark goes to ARM; data symbols are ignored.
- ARM: a mark (Pr) goes to TRACK with pos=1 and pulses pps; a data symbol returns to SEARCH without frame_err.
REQ-018 In TRACK, pos (7-bit) advances by one per symbol.
- pos 9,19,...,99 must be marks; all other pos values must be data.
- After pos=99, the next symbol is pos=0 (Pr) and must be a mark.
REQ-019 Each accepted Pr in TRACK pulses pps in the cycle after the irig_mark pulse; locked stays high.
REQ-020 Data bits are captured LSB-first into the field registers.
- Seconds: units pos 1-4, tens pos 6-8.
- Minutes: units 10-13, tens 15-17.
- Hours: units 20-23, tens 25-26.
- Day: units 30-33, tens 35-38, hundreds 40-41.
- Year: units 50-53, tens 55-58.
- All other data positions are discarded.
REQ-021 On acceptance of the pos=99 mark, all ts_* outputs update together and ts_valid pulses in the same cycle, one cycle after the input pulse.
- ts_* outputs hold their values until the next update.
REQ-022 In TRACK, any of the following pulses frame_err, clears locked and goes to SEARCH, all one cycle after the event:
- a wrong symbol type at any position;
- more than one input high in the same cycle;
- TIMEOUT_CYCLES elapsed since the last symbol.
REQ-023 The aborted frame raises no ts_valid; ts_* keep their last valid values.
REQ-024 locked rises with the first accepted Pr (ARM to TRACK) and falls only per REQ-022 or reset.
REQ-025 The watchdog counter clears on every symbol and saturates (does not wrap) at TIMEOUT_CYCLES.
- It is active in ARM and TRACK; TIMEOUT in ARM returns to SEARCH without frame_err.
REQ-026 Multiple inputs high in the same cycle in SEARCH or ARM are treated as no symbol.
REQ-027 All outputs are registered.

Reset
REQ-028 While rst is high at a clk edge:
- state becomes SEARCH;
- pos, shift registers and watchdog become 0;
- locked, pps, ts_valid and frame_err become 0;
- all ts_* become 0.
REQ-029 Reset mid-frame discards the partial frame and emits no ts_valid or frame_err.

Structure
REQ-030 A shared package irig_pkg holds:
- the FSM state enum;
- the field start and end positions;
- the marker positions (pos mod 10 = 9);
- the TIMEOUT_CYCLES default and the field widths.
REQ-031 The watchdog is a separate sub-module irig_watchdog (clear, enable, timeout pulse), reusable by other IRIG blocks.

Verification
REQ-032 Scenario 1: two marks, then a legal frame encoding 23:59:58, day 365, year 24 -> locked=1 after the second mark and pps pulses.
- At the pos=99 mark: ts_valid=1, ts_sec=7'h58, ts_min=7'h59, ts_hour=6'h23, ts_day=10'h365, ts_year=8'h24.
REQ-033 Scenario 2: locked, then a d1 at pos 19 -> frame_err one cycle later, locked=0, no ts_valid, ts_* unchanged.
REQ-034 Scenario 3: locked, then the input is silent for 150000 cycles.
- frame_err at the first cycle with watchdog=150000.
- Not asserted at 149999.
REQ-035 Scenario 4: irig_mark and irig_d0 high in the same cycle while locked -> frame_err and SEARCH.
- The same input while in SEARCH -> no state change.
REQ-036 Scenario 5: rst at pos 45 -> all outputs 0 next cycle.
- A following full legal frame relocks and yields correct ts_* values.
REQ-037 Scenario 6: three consecutive legal frames -> exactly 3 ts_valid pulses and 3 pps pulses after lock, each 100 symbols apart.
